// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction fetch unit.
//   fetch_state_t        - fetch FSM state encoding (IDLE / REQ / DRAIN)
//   DEFAULT_*            - default widths and prefetch depth
//   count_width()        - bits needed to hold an occupancy count 0..depth
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH_IDLE  = 2'd0,
        FETCH_REQ   = 2'd1,
        FETCH_DRAIN = 2'd2
    } fetch_state_t;

    localparam int unsigned DEFAULT_DATA_WIDTH  = 16;
    localparam int unsigned DEFAULT_INSTR_WIDTH = 16;
    localparam int unsigned DEFAULT_FIFO_DEPTH  = 2;

    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous prefetch FIFO, depth a power of two.
// Ports:
//   clk, clr            - clock, asynchronous active-low reset
//   push, push_data     - write an entry (caller guarantees not full)
//   pop                 - consume the head entry (ignored when empty)
//   flush               - empty the FIFO; takes priority over push
//   count               - current occupancy
//   head, not_empty     - head entry and its valid flag
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned width = DEFAULT_DATA_WIDTH + DEFAULT_INSTR_WIDTH,
    parameter int unsigned depth = DEFAULT_FIFO_DEPTH,
    localparam int unsigned ptr_width = $clog2(depth),
    localparam int unsigned cnt_width = count_width(depth)
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 push,
    input  logic [width-1:0]     push_data,
    input  logic                 pop,
    input  logic                 flush,
    output logic [cnt_width-1:0] count,
    output logic [width-1:0]     head,
    output logic                 not_empty
);

    logic [width-1:0]     mem [depth];
    logic [ptr_width-1:0] rd_ptr;
    logic [ptr_width-1:0] wr_ptr;
    logic                 do_pop;

    assign not_empty = (count != '0);
    assign do_pop    = pop && not_empty;
    assign head      = mem[rd_ptr];

    // Pointers are exactly log2(depth) bits wide, so they wrap on their own.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            mem    <= '{default: '0};
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + ptr_width'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + ptr_width'(1);
            end
            if (push && !do_pop) begin
                count <= count + cnt_width'(1);
            end else if (!push && do_pop) begin
                count <= count - cnt_width'(1);
            end
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetches instructions at the PC over a req/ack memory
// handshake into a prefetch FIFO and presents them to the decoder.
// Ports:
//   clk, clr                         - clock, asynchronous active-low reset
//   pc_addr                          - current PC value
//   pc_up, pc_load, pc_data          - PC increment / load controls (combinational)
//   mem_req, mem_addr                - registered read request, held until ack
//   mem_ack, mem_rdata               - read completion and data
//   redirect_valid, redirect_addr    - fetch restart pulse and target
//   instr_valid, instr_ready         - decoder handshake on the FIFO head
//   instr_data, instr_addr           - FIFO head instruction and its address
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned data_width  = DEFAULT_DATA_WIDTH,
    parameter int unsigned instr_width = DEFAULT_INSTR_WIDTH,
    parameter int unsigned fifo_depth  = DEFAULT_FIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic [data_width-1:0]  pc_addr,
    output logic                   pc_up,
    output logic                   pc_load,
    output logic [data_width-1:0]  pc_data,
    output logic                   mem_req,
    output logic [data_width-1:0]  mem_addr,
    input  logic                   mem_ack,
    input  logic [instr_width-1:0] mem_rdata,
    input  logic                   redirect_valid,
    input  logic [data_width-1:0]  redirect_addr,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [instr_width-1:0] instr_data,
    output logic [data_width-1:0]  instr_addr
);

    localparam int unsigned entry_width = data_width + instr_width;
    localparam int unsigned cnt_width   = count_width(fifo_depth);

    fetch_state_t           state;
    fetch_state_t           next_state;
    logic                   push;
    logic                   pop;
    logic                   fifo_full;
    logic [cnt_width-1:0]   fifo_count;
    logic [entry_width-1:0] fifo_head;

    assign fifo_full = (fifo_count == cnt_width'(fifo_depth));
    assign pop       = instr_valid && instr_ready;
    assign pc_data   = redirect_addr;
    assign {instr_addr, instr_data} = fifo_head;

    // State register
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= FETCH_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. A redirect without ack in REQ still owes the memory
    // its outstanding transfer, hence DRAIN rather than an immediate return.
    always_comb begin
        next_state = state;
        case (state)
            FETCH_IDLE: begin
                if (!redirect_valid && !fifo_full) begin
                    next_state = FETCH_REQ;
                end
            end
            FETCH_REQ: begin
                if (mem_ack) begin
                    next_state = FETCH_IDLE;
                end else if (redirect_valid) begin
                    next_state = FETCH_DRAIN;
                end
            end
            FETCH_DRAIN: begin
                if (mem_ack) begin
                    next_state = FETCH_IDLE;
                end
            end
            default: next_state = FETCH_IDLE;
        endcase
    end

    // Output logic. A redirect loads the PC in every state; only an
    // un-redirected ack in REQ keeps its data and advances the PC.
    always_comb begin
        pc_load = 1'b0;
        pc_up   = 1'b0;
        push    = 1'b0;
        if (clr) begin
            pc_load = redirect_valid;
            if (state == FETCH_REQ && mem_ack && !redirect_valid) begin
                pc_up = 1'b1;
                push  = 1'b1;
            end
        end
    end

    // Request registers: mem_req follows "a transfer is outstanding next
    // cycle"; the address is captured only when a new request is issued.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            mem_req  <= 1'b0;
            mem_addr <= '0;
        end else begin
            mem_req <= (next_state != FETCH_IDLE);
            if (state == FETCH_IDLE && next_state == FETCH_REQ) begin
                mem_addr <= pc_addr;
            end
        end
    end

    fetch_fifo #(
        .width (entry_width),
        .depth (fifo_depth)
    ) u_fifo (
        .clk       (clk),
        .clr       (clr),
        .push      (push),
        .push_data ({mem_addr, mem_rdata}),
        .pop       (pop),
        .flush     (redirect_valid),
        .count     (fifo_count),
        .head      (fifo_head),
        .not_empty (instr_valid)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: bench for instr_fetch_unit with a PC model, a
// variable-latency memory returning addr+0x1000, and a program-order
// reference: after reset the decoder must see 0,1,2,... and after every
// redirect it must see redirect_addr, redirect_addr+1, ... with no gaps.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        clr;
    logic [15:0] pc_addr;
    logic        pc_up;
    logic        pc_load;
    logic [15:0] pc_data;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        redirect_valid;
    logic [15:0] redirect_addr;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr_data;
    logic [15:0] instr_addr;

    int errors = 0;
    int checks = 0;

    int unsigned mem_lat;
    int unsigned wait_cnt;
    logic [15:0] pc_q;

    logic [15:0] exp_next;
    logic [15:0] got[$];
    int          n_ack;
    int          n_up;
    int          n_pops;
    logic        prev_req;
    logic        prev_ack;
    logic [15:0] prev_addr;

    typedef struct {
        logic [15:0] start;
        int unsigned lat;
        logic [15:0] e0;
        logic [15:0] e1;
        logic [15:0] e2;
    } vec_t;

    vec_t vecs[5];

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .data_width  (16),
        .instr_width (16),
        .fifo_depth  (2)
    ) dut (
        .clk            (clk),
        .clr            (clr),
        .pc_addr        (pc_addr),
        .pc_up          (pc_up),
        .pc_load        (pc_load),
        .pc_data        (pc_data),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_addr     (instr_addr)
    );

    // Program counter shared with the fetch unit (same reset net).
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) pc_q <= '0;
        else if (pc_load) pc_q <= pc_data;
        else if (pc_up) pc_q <= pc_q + 16'd1;
    end
    assign pc_addr = pc_q;

    // Memory: acks after mem_lat wait cycles of an outstanding request.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) wait_cnt <= 0;
        else if (!mem_req || mem_ack) wait_cnt <= 0;
        else wait_cnt <= wait_cnt + 1;
    end
    assign mem_ack   = mem_req && (wait_cnt >= mem_lat);
    assign mem_rdata = mem_addr + 16'h1000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: observe at the falling edge, return 1 time unit after the
    // next rising edge, where stimulus is changed.
    task automatic cycle();
        logic [15:0] d;
        @(negedge clk);
        if (!clr) begin
            exp_next = '0;
            got.delete();
            prev_req = 1'b0;
        end else begin
            if (prev_req && !prev_ack) begin
                check("req_held", mem_req, 1);
                check("addr_held", mem_addr, prev_addr);
            end
            check("up_load_excl", pc_up && pc_load, 0);
            check("load_on_redirect", pc_load, redirect_valid);
            if (pc_load) check("pc_data", pc_data, redirect_addr);
            if (mem_ack) n_ack++;
            if (pc_up) n_up++;
            if (redirect_valid) begin
                exp_next = redirect_addr;
                got.delete();
            end else if (instr_valid && instr_ready) begin
                d = instr_addr + 16'h1000;
                check("stream_addr", instr_addr, exp_next);
                check("stream_data", instr_data, d);
                got.push_back(instr_addr);
                exp_next = instr_addr + 16'd1;
                n_pops++;
            end
            prev_req  = mem_req;
            prev_ack  = mem_ack;
            prev_addr = mem_addr;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clr            = 1'b0;
        redirect_valid = 1'b1;
        redirect_addr  = 16'h1234;
        #1;
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_instr_valid", instr_valid, 0);
        check("rst_instr_data", instr_data, 0);
        check("rst_instr_addr", instr_addr, 0);
        check("rst_pc_load", pc_load, 0);
        check("rst_pc_up", pc_up, 0);
        cycle();
        cycle();
        redirect_valid = 1'b0;
        clr            = 1'b1;
        n_ack  = 0;
        n_up   = 0;
        n_pops = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{16'h0010, 0, 16'h0010, 16'h0011, 16'h0012};
        vecs[1] = '{16'h1234, 1, 16'h1234, 16'h1235, 16'h1236};
        vecs[2] = '{16'hFFFE, 2, 16'hFFFE, 16'hFFFF, 16'h0000};
        vecs[3] = '{16'hFFFF, 0, 16'hFFFF, 16'h0000, 16'h0001};
        vecs[4] = '{16'h8000, 3, 16'h8000, 16'h8001, 16'h8002};

        clr            = 1'b0;
        redirect_valid = 1'b0;
        redirect_addr  = '0;
        instr_ready    = 1'b1;
        mem_lat        = 0;
        exp_next       = '0;
        prev_req       = 1'b0;
        prev_ack       = 1'b0;
        prev_addr      = '0;
        n_ack = 0; n_up = 0; n_pops = 0;

        // Zero-wait memory, decoder always ready: latency and throughput.
        do_reset();
        cycle();
        check("t1_first_req", mem_req, 1);
        check("t1_first_addr", mem_addr, 0);
        check("t1_valid_early", instr_valid, 0);
        cycle();
        check("t1_first_valid", instr_valid, 1);
        check("t1_head_addr", instr_addr, 16'h0000);
        check("t1_head_data", instr_data, 16'h1000);
        n_ack = 0; n_up = 0;
        repeat (20) cycle();
        check("t1_acks_per_20", n_ack, 10);
        check("t1_ups_per_20", n_up, 10);
        check("t1_got_size", got.size() >= 3, 1);
        check("t1_got0", got[0], 16'h0000);
        check("t1_got1", got[1], 16'h0001);
        check("t1_got2", got[2], 16'h0002);

        // Decoder stalled: FIFO fills, issue stops, then resumes losslessly.
        instr_ready = 1'b0;
        mem_lat = 0;
        do_reset();
        repeat (12) cycle();
        check("t2_acks", n_ack, 2);
        check("t2_req_idle", mem_req, 0);
        check("t2_pc", pc_q, 16'h0002);
        check("t2_valid", instr_valid, 1);
        check("t2_head", instr_addr, 16'h0000);
        instr_ready = 1'b1;
        repeat (12) cycle();
        check("t2_got_size", got.size() >= 4, 1);
        check("t2_got0", got[0], 16'h0000);
        check("t2_got1", got[1], 16'h0001);
        check("t2_got2", got[2], 16'h0002);
        check("t2_got3", got[3], 16'h0003);

        // Redirect while a 3-wait request is outstanding: drain then restart.
        mem_lat = 3;
        instr_ready = 1'b1;
        do_reset();
        redirect_valid = 1'b1;
        redirect_addr  = 16'h0005;
        #1;
        check("t3_idle_load", pc_load, 1);
        check("t3_idle_data", pc_data, 16'h0005);
        cycle();
        redirect_valid = 1'b0;
        for (int k = 0; k < 50 && !(mem_req && mem_addr == 16'h0005); k++) cycle();
        check("t3_issue_5", mem_req && mem_addr == 16'h0005, 1);
        cycle();
        redirect_valid = 1'b1;
        redirect_addr  = 16'h0040;
        #1;
        check("t3_load", pc_load, 1);
        check("t3_load_data", pc_data, 16'h0040);
        check("t3_no_up", pc_up, 0);
        check("t3_no_ack_yet", mem_ack, 0);
        cycle();
        redirect_valid = 1'b0;
        check("t3_drain_req", mem_req, 1);
        check("t3_drain_addr", mem_addr, 16'h0005);
        check("t3_pc_loaded", pc_q, 16'h0040);
        cycle();
        check("t3_drain_ack", mem_ack, 1);
        check("t3_drain_no_up", pc_up, 0);
        cycle();
        check("t3_back_idle", mem_req, 0);
        check("t3_dropped", instr_valid, 0);
        cycle();
        check("t3_new_req", mem_req, 1);
        check("t3_new_addr", mem_addr, 16'h0040);
        for (int k = 0; k < 50 && got.size() < 1; k++) cycle();
        check("t3_got0", got[0], 16'h0040);

        // Redirect in the same cycle as ack, with one entry already buffered.
        instr_ready = 1'b0;
        mem_lat = 0;
        do_reset();
        for (int k = 0; k < 50 && n_ack < 1; k++) cycle();
        for (int k = 0; k < 50 && !mem_ack; k++) cycle();
        check("t4_ack_seen", mem_ack, 1);
        check("t4_buffered", instr_valid, 1);
        redirect_valid = 1'b1;
        redirect_addr  = 16'h0080;
        #1;
        check("t4_load", pc_load, 1);
        check("t4_up_beaten", pc_up, 0);
        cycle();
        redirect_valid = 1'b0;
        check("t4_flushed", instr_valid, 0);
        check("t4_idle", mem_req, 0);
        check("t4_pc", pc_q, 16'h0080);
        instr_ready = 1'b1;
        for (int k = 0; k < 50 && got.size() < 2; k++) cycle();
        check("t4_got0", got[0], 16'h0080);
        check("t4_got1", got[1], 16'h0081);

        // Table: restart address and memory latency vs first three fetches.
        foreach (vecs[i]) begin
            mem_lat = vecs[i].lat;
            instr_ready = 1'b1;
            do_reset();
            redirect_valid = 1'b1;
            redirect_addr  = vecs[i].start;
            cycle();
            redirect_valid = 1'b0;
            for (int k = 0; k < 80 && got.size() < 3; k++) cycle();
            check("tv_size", got.size() >= 3, 1);
            check("tv_e0", got[0], vecs[i].e0);
            check("tv_e1", got[1], vecs[i].e1);
            check("tv_e2", got[2], vecs[i].e2);
        end

        // Reset asserted in REQ with one buffered entry.
        instr_ready = 1'b0;
        mem_lat = 3;
        do_reset();
        for (int k = 0; k < 50 && n_ack < 1; k++) cycle();
        for (int k = 0; k < 50 && !mem_req; k++) cycle();
        check("t6_in_req", mem_req, 1);
        check("t6_buffered", instr_valid, 1);
        clr = 1'b0;
        #1;
        check("t6_req_dropped", mem_req, 0);
        check("t6_valid_dropped", instr_valid, 0);
        check("t6_no_up", pc_up, 0);
        check("t6_no_load", pc_load, 0);
        cycle();
        clr = 1'b1;
        instr_ready = 1'b1;
        for (int k = 0; k < 50 && got.size() < 2; k++) cycle();
        check("t6_got0", got[0], 16'h0000);
        check("t6_got1", got[1], 16'h0001);

        // Random traffic against the program-order reference.
        mem_lat = 0;
        instr_ready = 1'b1;
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            if (n % 200 == 0) mem_lat = $urandom_range(0, 3);
            instr_ready    = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 3) == 0)
                redirect_addr = 16'hFFFD + 16'($urandom_range(0, 3));
            else
                redirect_addr = 16'($urandom);
            cycle();
        end
        redirect_valid = 1'b0;
        check("rand_progress", n_pops >= 50, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
